line_buf_scheduler: RTL and testbench
=====================================

# line_buf_scheduler

Sequencer for the 8-bank, 2048-entry-per-bank line RAM in the PAL→HD upsampler. It runs in the HD pixel-clock domain and takes synchronized line and frame events from the PAL writer and the HD reader. It issues write-bank and read-base addresses, and decides on each HD line whether to repeat the current PAL line or advance to the next one. A fractional vertical step accumulator drives that decision, guarded by fill-level underflow/overflow checks.

## Interface
Parameters:
- NBANK, 8, number of line banks (power of two)
- BANK_AW, 11, address bits per bank; total RAM address width = log2(NBANK)+BANK_AW = 14
- PAL_OFFSET_HZ, 'h80, fixed horizontal read pre-offset in pixels
- PRIME_LINES, 2, lines that must be buffered before reading starts

Ports:
- clk_out  in  1  HD pixel-domain clock
- reset_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse, PAL vsync falling edge (already synchronized)
- i_wr_line_done  in  1  one-cycle pulse, PAL writer finished a line
- i_rd_line_start  in  1  one-cycle pulse, HD hsync rising edge
- i_v_step  in  8  vertical step, Q0.8 PAL lines per HD line (0 = never advance)
- i_hd_hoffset  in  8  user horizontal offset
- i_hd_voffset  in  8  HD lines blanked after frame start
- o_wr_addr  out  14  write base address {wr_bank, 11'b0}
- o_rd_addr  out  14  read base address, see Operation
- o_rd_valid  out  1  1 = current HD line shows buffer data, 0 = black
- o_fill  out  4  banks written and not yet released (0..NBANK)
- o_underflow  out  1  one-cycle pulse: advance wanted, no line available
- o_overflow  out  1  one-cycle pulse: writer overran the reader

## Operation
- State machine states: IDLE, PRIME, RUN.
  - Reset → IDLE.
  - i_frame_start from any state → PRIME. On entry: wr_bank=0, rd_bank=0, fill=0, phase=0, vskip=i_hd_voffset.
  - IDLE ignores line events.
  - PRIME → RUN when fill ≥ PRIME_LINES.
- Write side, in PRIME and RUN, on i_wr_line_done:
  - wr_bank += 1, mod NBANK.
  - fill += 1.
  - If fill was already NBANK: fill stays NBANK, rd_bank += 1 (oldest line dropped), o_overflow pulses.
- Read side, RUN only, on i_rd_line_start:
  - If vskip ≠ 0: vskip -= 1, o_rd_valid=0, no advance.
  - Otherwise o_rd_valid=1, and sum = phase + i_v_step as a 9-bit value.
  - If sum[8]=1 and fill ≥ 2: rd_bank += 1, fill -= 1, phase = sum[7:0].
  - If sum[8]=1 and fill < 2: no advance, phase = 8'hFF (saturate, retry next line), o_underflow pulses.
  - If sum[8]=0: phase = sum[7:0] (repeat the line).
- In PRIME, i_rd_line_start sets o_rd_valid=0 and changes nothing else.
- Address arithmetic:
  - o_rd_addr = ({rd_bank, 11'b0} − PAL_OFFSET_HZ − i_hd_hoffset), mod 2^14.
  - Wrap below 0 into bank 7 is intended.
- Simultaneous i_wr_line_done and i_rd_line_start:
  - fill_next = fill + 1 − advance.
  - The advance check uses the pre-increment fill.
  - The overflow check uses fill after the read release.
- i_frame_start in the same cycle as any line event: the frame start wins and the line events are discarded.

## Timing
- All outputs are registered. Reset values:
  - o_wr_addr=0, o_rd_addr=14'h0000−PAL_OFFSET_HZ (i_hd_hoffset treated as 0 during reset)
  - o_rd_valid=0, o_fill=0, o_underflow=0, o_overflow=0
- o_wr_addr updates 1 cycle after i_wr_line_done.
- o_rd_addr and o_rd_valid update 1 cycle after i_rd_line_start, and hold for the whole HD line.
- o_rd_addr follows i_hd_hoffset changes only at the next i_rd_line_start.
- o_underflow and o_overflow are high for exactly 1 cycle, 1 cycle after the causing event.
- Line-event pulses must be ≥2 cycles apart per source. Back-to-back pulses from the same source are a protocol violation; no behaviour is defined.
- reset_n assert: immediate, asynchronous. Deassert: synchronized within the block, 2-flop release.

## Structure
- Shared package upsample_pkg holds:
  - NBANK, BANK_AW, the bank-base function bank_base(bank) = bank << BANK_AW
  - the state enum {IDLE, PRIME, RUN}
- One sub-module, v_step_accum: 9-bit phase add, saturation and advance request. Keeps the ratio logic unit-testable.
- Everything else is flat in line_buf_scheduler, about 200 lines.

## Test plan
- Reset, then i_frame_start, then 2× i_wr_line_done → o_fill=2, state RUN, o_wr_addr=14'h1000.
- i_v_step=8'h40, fill=4, 8 HD lines → rd_bank advances on lines 4 and 8 only, o_rd_addr=14'h0800−'h80−hoffset after line 4.
- 9 i_wr_line_done with no reads → 9th pulses o_overflow, o_fill=8, rd_bank=1.
- i_v_step=8'hFF, fill=1 at a read → o_underflow pulse, rd_bank unchanged, next line advances once fill=2.
- i_hd_voffset=3 → first 3 HD lines in RUN give o_rd_valid=0, 4th gives 1.
- i_frame_start coincident with i_wr_line_done and i_rd_line_start → pointers=0, o_fill=0, PRIME; reset_n pulsed mid-RUN → all outputs at reset values within 1 cycle.

Source files
------------

// File: rtl/upsample_pkg.sv
// Shared definitions for the PAL->HD upsampler line RAM sequencing.
// Holds the bank geometry, the sequencer state enumeration and the
// bank-base address helper.
package upsample_pkg;

  localparam int NBANK   = 8;
  localparam int BANK_AW = 11;
  localparam int BANK_W  = $clog2(NBANK);
  localparam int ADDR_W  = BANK_W + BANK_AW;
  localparam int FILL_W  = $clog2(NBANK + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // First RAM address of a bank.
  function automatic logic [ADDR_W-1:0] bank_base(input logic [BANK_W-1:0] bank);
    return {bank, {BANK_AW{1'b0}}};
  endfunction

endpackage

// File: rtl/line_buf_scheduler_if.sv
// Event and address bus between the line-buffer sequencer and its
// surroundings.
//   i_frame_start / i_wr_line_done / i_rd_line_start : one-cycle event pulses
//   i_v_step, i_hd_hoffset, i_hd_voffset             : static configuration
//   o_wr_addr / o_rd_addr                            : bank base addresses
//   o_rd_valid, o_fill, o_underflow, o_overflow      : status
// master drives the events, slave is the sequencer.
interface line_buf_scheduler_if;
  import upsample_pkg::*;

  logic              i_frame_start;
  logic              i_wr_line_done;
  logic              i_rd_line_start;
  logic [7:0]        i_v_step;
  logic [7:0]        i_hd_hoffset;
  logic [7:0]        i_hd_voffset;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_rd_valid;
  logic [FILL_W-1:0] o_fill;
  logic              o_underflow;
  logic              o_overflow;

  modport master (
    output i_frame_start, i_wr_line_done, i_rd_line_start,
    output i_v_step, i_hd_hoffset, i_hd_voffset,
    input  o_wr_addr, o_rd_addr, o_rd_valid, o_fill, o_underflow, o_overflow
  );

  modport slave (
    input  i_frame_start, i_wr_line_done, i_rd_line_start,
    input  i_v_step, i_hd_hoffset, i_hd_voffset,
    output o_wr_addr, o_rd_addr, o_rd_valid, o_fill, o_underflow, o_overflow
  );

endinterface

// File: rtl/line_buf_scheduler_v_step_accum.sv
// Fractional vertical step accumulator.
//   phase      : current Q0.8 phase
//   v_step     : Q0.8 PAL lines per HD line
//   fill_ok    : at least two lines buffered, so an advance is possible
//   advance    : move to the next PAL line
//   underflow  : advance wanted but no line available
//   phase_next : phase to store; saturates at 8'hFF on underflow so the
//                next HD line retries the advance
module v_step_accum
  import upsample_pkg::*;
(
  input  logic [7:0] phase,
  input  logic [7:0] v_step,
  input  logic       fill_ok,
  output logic       advance,
  output logic       underflow,
  output logic [7:0] phase_next
);

  logic [8:0] sum;

  always_comb begin
    sum        = {1'b0, phase} + {1'b0, v_step};
    advance    = 1'b0;
    underflow  = 1'b0;
    phase_next = sum[7:0];
    if (sum[8]) begin
      if (fill_ok) begin
        advance = 1'b1;
      end else begin
        underflow  = 1'b1;
        phase_next = 8'hFF;
      end
    end
  end

endmodule

// File: rtl/line_buf_scheduler.sv
// Line RAM sequencer for the PAL->HD upsampler, HD pixel-clock domain.
//   clk_out : HD pixel clock
//   reset_n : asynchronous active-low reset, release synchronized here
//   bus     : event inputs, configuration, bank addresses and status
// Tracks write/read banks and fill level, and on every HD line decides
// whether to repeat the current PAL line or advance to the next one.
module line_buf_scheduler
  import upsample_pkg::*;
#(
  parameter int NBANK         = upsample_pkg::NBANK,
  parameter int BANK_AW       = upsample_pkg::BANK_AW,
  parameter int PAL_OFFSET_HZ = 'h80,
  parameter int PRIME_LINES   = 2
) (
  input logic                clk_out,
  input logic                reset_n,
  line_buf_scheduler_if.slave bus
);

  localparam int BANK_W = $clog2(NBANK);
  localparam int AW     = BANK_W + BANK_AW;
  localparam int FW     = $clog2(NBANK + 1);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_PRIME = 2'(ST_PRIME);
  localparam logic [1:0] S_RUN   = 2'(ST_RUN);

  localparam logic [AW-1:0] HZ_OFF = AW'(PAL_OFFSET_HZ);
  localparam logic [FW-1:0] FULL   = FW'(NBANK);
  localparam logic [FW-1:0] PRIMED = FW'(PRIME_LINES);

  function automatic logic [AW-1:0] read_base(input logic [BANK_W-1:0] bank,
                                              input logic [7:0]        hoff);
    return {bank, {BANK_AW{1'b0}}} - HZ_OFF - AW'(hoff);
  endfunction

  logic [1:0]        rst_sync;
  logic              rst_int_n;

  logic [1:0]        state,  state_n;
  logic [BANK_W-1:0] wr_bank, wr_bank_n;
  logic [BANK_W-1:0] rd_bank, rd_bank_n;
  logic [FW-1:0]     fill,    fill_n, fill_rel;
  logic [7:0]        phase,   phase_n;
  logic [7:0]        vskip,   vskip_n;
  logic [AW-1:0]     rd_addr, rd_addr_n;
  logic              rd_valid, rd_valid_n;
  logic              under,   under_n;
  logic              over,    over_n;
  logic              adv;

  logic              fill_ok, acc_adv, acc_under;
  logic [7:0]        acc_phase;

  // Reset asserts immediately, releases two clocks after reset_n rises.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign fill_ok = (fill >= FW'(2));

  v_step_accum u_acc (
    .phase      (phase),
    .v_step     (bus.i_v_step),
    .fill_ok    (fill_ok),
    .advance    (acc_adv),
    .underflow  (acc_under),
    .phase_next (acc_phase)
  );

  always_comb begin
    state_n    = state;
    wr_bank_n  = wr_bank;
    rd_bank_n  = rd_bank;
    fill_n     = fill;
    fill_rel   = fill;
    phase_n    = phase;
    vskip_n    = vskip;
    rd_addr_n  = rd_addr;
    rd_valid_n = rd_valid;
    under_n    = 1'b0;
    over_n     = 1'b0;
    adv        = 1'b0;

    if (bus.i_frame_start) begin
      // Frame start overrides any coincident line events.
      state_n    = S_PRIME;
      wr_bank_n  = '0;
      rd_bank_n  = '0;
      fill_n     = '0;
      phase_n    = '0;
      vskip_n    = bus.i_hd_voffset;
      rd_valid_n = 1'b0;
      rd_addr_n  = read_base('0, bus.i_hd_hoffset);
    end else if (state != S_IDLE) begin
      if (bus.i_rd_line_start) begin
        rd_valid_n = 1'b0;
        if (state == S_RUN) begin
          if (vskip != 8'd0) begin
            vskip_n = vskip - 8'd1;
          end else begin
            rd_valid_n = 1'b1;
            phase_n    = acc_phase;
            adv        = acc_adv;
            under_n    = acc_under;
          end
        end
      end

      // Read release first, so a simultaneous write sees the freed bank.
      fill_rel  = fill - FW'(adv);
      rd_bank_n = rd_bank + BANK_W'(adv);
      fill_n    = fill_rel;

      if (bus.i_wr_line_done) begin
        wr_bank_n = wr_bank + BANK_W'(1);
        if (fill_rel == FULL) begin
          over_n    = 1'b1;
          rd_bank_n = rd_bank_n + BANK_W'(1);
        end else begin
          fill_n = fill_rel + FW'(1);
        end
      end

      if (bus.i_rd_line_start) rd_addr_n = read_base(rd_bank_n, bus.i_hd_hoffset);

      if (state == S_PRIME && fill_n >= PRIMED) state_n = S_RUN;
    end
  end

  always_ff @(posedge clk_out or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= S_IDLE;
      wr_bank  <= '0;
      rd_bank  <= '0;
      fill     <= '0;
      phase    <= '0;
      vskip    <= '0;
      rd_addr  <= read_base('0, 8'd0);
      rd_valid <= 1'b0;
      under    <= 1'b0;
      over     <= 1'b0;
    end else begin
      state    <= state_n;
      wr_bank  <= wr_bank_n;
      rd_bank  <= rd_bank_n;
      fill     <= fill_n;
      phase    <= phase_n;
      vskip    <= vskip_n;
      rd_addr  <= rd_addr_n;
      rd_valid <= rd_valid_n;
      under    <= under_n;
      over     <= over_n;
    end
  end

  assign bus.o_wr_addr   = {wr_bank, {BANK_AW{1'b0}}};
  assign bus.o_rd_addr   = rd_addr;
  assign bus.o_rd_valid  = rd_valid;
  assign bus.o_fill      = fill;
  assign bus.o_underflow = under;
  assign bus.o_overflow  = over;

endmodule

// File: tb/tb_line_buf_scheduler.sv
// Self-checking bench for line_buf_scheduler: directed scenarios plus a
// randomized run against a line-level reference model.
module tb_line_buf_scheduler;
  import upsample_pkg::*;

  logic clk;
  logic reset_n;
  line_buf_scheduler_if bus();

  line_buf_scheduler dut (
    .clk_out (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: banks, fill level and phase as plain integers.
  int m_wr, m_rd, m_fill, m_phase, m_vskip, m_addr;
  bit m_active, m_run, m_valid, m_under, m_over;
  logic [7:0] v_step, hoff, voff;

  function automatic int exp_addr(int bank, int h);
    return ((bank * 2048 - 'h80 - h) % 16384 + 16384) % 16384;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_fill = 0; m_phase = 0; m_vskip = 0;
    m_addr = exp_addr(0, 0);
    m_active = 0; m_run = 0; m_valid = 0; m_under = 0; m_over = 0;
  endtask

  task automatic model_event(bit fs, bit wr, bit rd);
    int sum;
    bit advance;
    m_under = 0; m_over = 0; advance = 0;
    if (fs) begin
      m_active = 1; m_run = 0;
      m_wr = 0; m_rd = 0; m_fill = 0; m_phase = 0; m_vskip = voff;
      m_valid = 0; m_addr = exp_addr(0, hoff);
    end else if (m_active) begin
      if (rd) begin
        m_valid = 0;
        if (m_run) begin
          if (m_vskip > 0) m_vskip--;
          else begin
            m_valid = 1;
            sum = m_phase + v_step;
            if (sum >= 256) begin
              if (m_fill >= 2) begin advance = 1; m_phase = sum - 256; end
              else begin m_under = 1; m_phase = 255; end
            end else m_phase = sum;
          end
        end
      end
      if (advance) begin m_fill--; m_rd = (m_rd + 1) % 8; end
      if (wr) begin
        m_wr = (m_wr + 1) % 8;
        if (m_fill == 8) begin m_over = 1; m_rd = (m_rd + 1) % 8; end
        else m_fill++;
      end
      if (rd) m_addr = exp_addr(m_rd, hoff);
      if (!m_run && m_fill >= 2) m_run = 1;
    end
  endtask

  // One event cycle followed by at least one idle cycle; returns at a
  // falling edge with the registered response visible.
  task automatic step(bit fs, bit wr, bit rd);
    @(negedge clk);
    bus.i_frame_start   = fs;
    bus.i_wr_line_done  = wr;
    bus.i_rd_line_start = rd;
    bus.i_v_step        = v_step;
    bus.i_hd_hoffset    = hoff;
    bus.i_hd_voffset    = voff;
    @(posedge clk);
    model_event(fs, wr, rd);
    @(negedge clk);
    bus.i_frame_start   = 1'b0;
    bus.i_wr_line_done  = 1'b0;
    bus.i_rd_line_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_wr_addr !== 14'h0000) begin errors++; $display("FAIL reset_wr_addr got %h want 0000", bus.o_wr_addr); end
    checks++; if (bus.o_rd_addr !== 14'h3F80) begin errors++; $display("FAIL reset_rd_addr got %h want 3f80", bus.o_rd_addr); end
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.o_rd_valid); end
    checks++; if (bus.o_fill !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", bus.o_fill); end
    checks++; if (bus.o_underflow !== 1'b0 || bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", bus.o_underflow, bus.o_overflow); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  task automatic test_prime();
    voff = 0; v_step = 0; hoff = 0;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    checks++; if (bus.o_fill !== 4'd2) begin errors++; $display("FAIL prime_fill got %0d want 2", bus.o_fill); end
    checks++; if (bus.o_wr_addr !== 14'h1000) begin errors++; $display("FAIL prime_wr_addr got %h want 1000", bus.o_wr_addr); end
    step(0, 0, 1);
    checks++; if (bus.o_rd_valid !== 1'b1) begin errors++; $display("FAIL prime_run_valid got %b want 1", bus.o_rd_valid); end
  endtask

  task automatic test_step_advance();
    int bank;
    voff = 0; v_step = 8'h40; hoff = 8'($urandom_range(0, 255));
    step(1, 0, 0);
    repeat (4) step(0, 1, 0);
    checks++; if (bus.o_fill !== 4'd4) begin errors++; $display("FAIL adv_fill_start got %0d want 4", bus.o_fill); end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1);
      bank = (i >= 8) ? 2 : (i >= 4) ? 1 : 0;
      checks++;
      if (bus.o_rd_addr !== 14'(exp_addr(bank, hoff))) begin
        errors++; $display("FAIL adv_rd_addr line %0d got %h want %h", i, bus.o_rd_addr, 14'(exp_addr(bank, hoff)));
      end
    end
    checks++; if (bus.o_fill !== 4'd2) begin errors++; $display("FAIL adv_fill_end got %0d want 2", bus.o_fill); end
  endtask

  task automatic test_overflow();
    voff = 0; v_step = 0; hoff = 8'h10;
    step(1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 0);
      checks++;
      if (bus.o_overflow !== (i == 9) || bus.o_fill !== 4'((i > 8) ? 8 : i)) begin
        errors++; $display("FAIL ovf_write %0d got ovf=%b fill=%0d want ovf=%b fill=%0d", i, bus.o_overflow, bus.o_fill, (i == 9), (i > 8) ? 8 : i);
      end
    end
    @(negedge clk);
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %b want 0", bus.o_overflow); end
    step(0, 0, 1);
    checks++; if (bus.o_rd_addr !== 14'(exp_addr(1, 8'h10))) begin errors++; $display("FAIL ovf_rd_bank got %h want %h", bus.o_rd_addr, 14'(exp_addr(1, 8'h10))); end
  endtask

  task automatic test_underflow();
    voff = 0; v_step = 8'h80; hoff = 8'h22;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    checks++; if (bus.o_fill !== 4'd1) begin errors++; $display("FAIL udf_setup_fill got %0d want 1", bus.o_fill); end
    v_step = 8'hFF;
    step(0, 0, 1);
    step(0, 0, 1);
    checks++; if (bus.o_underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got %b want 1", bus.o_underflow); end
    checks++; if (bus.o_rd_addr !== 14'(exp_addr(1, 8'h22))) begin errors++; $display("FAIL udf_rd_addr got %h want %h", bus.o_rd_addr, 14'(exp_addr(1, 8'h22))); end
    @(negedge clk);
    checks++; if (bus.o_underflow !== 1'b0) begin errors++; $display("FAIL udf_pulse_width got %b want 0", bus.o_underflow); end
    step(0, 1, 0);
    step(0, 0, 1);
    checks++; if (bus.o_rd_addr !== 14'(exp_addr(2, 8'h22)) || bus.o_underflow !== 1'b0) begin
      errors++; $display("FAIL udf_retry got addr=%h udf=%b want addr=%h udf=0", bus.o_rd_addr, bus.o_underflow, 14'(exp_addr(2, 8'h22)));
    end
  endtask

  task automatic test_voffset();
    voff = 3; v_step = 0; hoff = 0;
    step(1, 0, 0);
    step(0, 0, 1);
    checks++; if (bus.o_rd_valid !== 1'b0) begin errors++; $display("FAIL vofs_prime_valid got %b want 0", bus.o_rd_valid); end
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1);
      checks++;
      if (bus.o_rd_valid !== (i == 4)) begin errors++; $display("FAIL vofs_line %0d got %b want %b", i, bus.o_rd_valid, (i == 4)); end
    end
  endtask

  task automatic test_collision();
    voff = 0; v_step = 8'h10; hoff = 8'h05;
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 1);
    checks++; if (bus.o_wr_addr !== 14'h0000 || bus.o_fill !== 4'd0) begin
      errors++; $display("FAIL coll_restart got wr=%h fill=%0d want wr=0000 fill=0", bus.o_wr_addr, bus.o_fill);
    end
    step(0, 1, 1);
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_fill !== 4'd1 || bus.o_wr_addr !== 14'h0800) begin
      errors++; $display("FAIL coll_prime got valid=%b fill=%0d wr=%h want valid=0 fill=1 wr=0800", bus.o_rd_valid, bus.o_fill, bus.o_wr_addr);
    end
    step(0, 1, 0);
    step(0, 0, 1);
    checks++; if (bus.o_rd_valid !== 1'b1) begin errors++; $display("FAIL coll_run_valid got %b want 1", bus.o_rd_valid); end
  endtask

  task automatic test_random();
    bit fs, wr, rd;
    voff = 0; v_step = 8'h60; hoff = 0;
    step(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      fs = ($urandom_range(0, 39) == 0);
      wr = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      hoff = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) v_step = 8'($urandom_range(0, 255));
      if (fs) voff = 8'($urandom_range(0, 3));
      step(fs, wr, rd);
      checks++;
      if (bus.o_wr_addr !== 14'(m_wr * 2048) || bus.o_rd_addr !== 14'(m_addr) ||
          bus.o_rd_valid !== m_valid || bus.o_fill !== 4'(m_fill) ||
          bus.o_underflow !== m_under || bus.o_overflow !== m_over) begin
        errors++;
        $display("FAIL rand_step %0d got wr=%h rd=%h v=%b f=%0d u=%b o=%b want wr=%h rd=%h v=%b f=%0d u=%b o=%b",
                 i, bus.o_wr_addr, bus.o_rd_addr, bus.o_rd_valid, bus.o_fill, bus.o_underflow, bus.o_overflow,
                 14'(m_wr * 2048), 14'(m_addr), m_valid, m_fill, m_under, m_over);
      end
    end
  endtask

  task automatic test_async_reset();
    voff = 0; v_step = 8'h20; hoff = 8'h33;
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.o_wr_addr !== 14'h0000 || bus.o_rd_addr !== 14'h3F80 || bus.o_rd_valid !== 1'b0 ||
        bus.o_fill !== 4'd0 || bus.o_underflow !== 1'b0 || bus.o_overflow !== 1'b0) begin
      errors++; $display("FAIL async_reset got wr=%h rd=%h v=%b f=%0d want wr=0000 rd=3f80 v=0 f=0",
                         bus.o_wr_addr, bus.o_rd_addr, bus.o_rd_valid, bus.o_fill);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
    step(0, 1, 1);
    checks++; if (bus.o_fill !== 4'd0 || bus.o_wr_addr !== 14'h0000) begin
      errors++; $display("FAIL idle_ignores got fill=%0d wr=%h want fill=0 wr=0000", bus.o_fill, bus.o_wr_addr);
    end
  endtask

  initial begin
    bus.i_frame_start   = 1'b0;
    bus.i_wr_line_done  = 1'b0;
    bus.i_rd_line_start = 1'b0;
    bus.i_v_step        = 8'h00;
    bus.i_hd_hoffset    = 8'h00;
    bus.i_hd_voffset    = 8'h00;
    v_step = 0; hoff = 0; voff = 0;
    model_reset();
    test_reset();
    test_prime();
    test_step_advance();
    test_overflow();
    test_underflow();
    test_voffset();
    test_collision();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
